// File: rtl/tfrag_cfg_loader.sv
// tfrag_cfg_loader
// Loads the input-inverter selects (XAS1, XAS2, XBS1, XBS2) of a column of
// T_FRAG cells. A framed byte stream (HDR, NUM_FRAGS/2 payload bytes, XOR
// checksum) is captured into a shadow register. On a good checksum the shadow
// is shifted MSB-first onto the serial config chain, and then CFG_UPD is pulsed.
//
// Ports:
//   CLK        clock, rising edge
//   RSTN       asynchronous active-low reset
//   DIN        frame byte
//   DIN_VALID  DIN holds a valid byte
//   DIN_READY  block accepts a byte this cycle
//   CFG_SDO    serial chain data (0 while CFG_SEN is low)
//   CFG_SEN    chain shift enable, one bit per cycle
//   CFG_UPD    one-cycle latch strobe for the cells
//   BUSY       frame in progress or chain being written
//   DONE       sticky, last frame committed
//   ERR        sticky, last frame failed its checksum
//
// state   | meaning
// IDLE    | hunting for the header byte, other bytes are discarded
// PAYLOAD | collecting payload bytes into the shadow register
// CHECK   | comparing the checksum byte against the running XOR
// SHIFT   | N cycles driving the shadow onto the chain, MSB first
// UPDATE  | one-cycle CFG_UPD strobe, then DONE
module tfrag_cfg_loader #(
  parameter int          NUM_FRAGS = 8,
  parameter logic [7:0]  HDR       = 8'hA5
) (
  input  logic       CLK,
  input  logic       RSTN,
  input  logic [7:0] DIN,
  input  logic       DIN_VALID,
  output logic       DIN_READY,
  output logic       CFG_SDO,
  output logic       CFG_SEN,
  output logic       CFG_UPD,
  output logic       BUSY,
  output logic       DONE,
  output logic       ERR
);

  localparam int N   = 4 * NUM_FRAGS;
  localparam int NB  = NUM_FRAGS / 2;
  localparam int BCW = (NB > 1) ? $clog2(NB) : 1;
  localparam int BTW = $clog2(N);

  typedef enum logic [2:0] {
    IDLE, PAYLOAD, CHECK, SHIFT, UPDATE
  } state_t;

  state_t           state;
  logic [N-1:0]     shadow;
  logic [BCW-1:0]   byte_cnt;
  logic [BTW-1:0]   bit_cnt;
  logic [7:0]       run_xor;
  logic             xfer;

  assign xfer = DIN_VALID && DIN_READY;

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state     <= IDLE;
      shadow    <= '0;
      byte_cnt  <= '0;
      bit_cnt   <= '0;
      run_xor   <= '0;
      DIN_READY <= 1'b1;
      CFG_SDO   <= 1'b0;
      CFG_SEN   <= 1'b0;
      CFG_UPD   <= 1'b0;
      BUSY      <= 1'b0;
      DONE      <= 1'b0;
      ERR       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (xfer && DIN == HDR) begin
            DONE     <= 1'b0;
            ERR      <= 1'b0;
            run_xor  <= '0;
            byte_cnt <= '0;
            BUSY     <= 1'b1;
            state    <= PAYLOAD;
          end
        end
        PAYLOAD: begin
          if (xfer) begin
            // Byte k holds cell 2k in its low nibble and cell 2k+1 in its
            // high nibble, so it lands directly on shadow bits 8k..8k+7.
            for (int k = 0; k < NB; k++) begin
              if (byte_cnt == BCW'(k)) shadow[8*k +: 8] <= DIN;
            end
            run_xor <= run_xor ^ DIN;
            if (byte_cnt == BCW'(NB - 1)) state <= CHECK;
            else                          byte_cnt <= byte_cnt + 1'b1;
          end
        end
        CHECK: begin
          if (xfer) begin
            if (DIN == run_xor) begin
              // First chain bit is presented together with CFG_SEN so the
              // shift window is exactly N cycles.
              DIN_READY <= 1'b0;
              CFG_SEN   <= 1'b1;
              CFG_SDO   <= shadow[N-1];
              bit_cnt   <= BTW'(N - 1);
              state     <= SHIFT;
            end else begin
              ERR   <= 1'b1;
              BUSY  <= 1'b0;
              state <= IDLE;
            end
          end
        end
        SHIFT: begin
          if (bit_cnt == '0) begin
            CFG_SEN <= 1'b0;
            CFG_SDO <= 1'b0;
            CFG_UPD <= 1'b1;
            state   <= UPDATE;
          end else begin
            bit_cnt <= bit_cnt - 1'b1;
            CFG_SDO <= shadow[bit_cnt - 1'b1];
          end
        end
        UPDATE: begin
          CFG_UPD   <= 1'b0;
          DONE      <= 1'b1;
          BUSY      <= 1'b0;
          DIN_READY <= 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tfrag_cfg_loader.sv
module tb_tfrag_cfg_loader;

  localparam int NF = 4;

  logic       CLK = 1'b0;
  logic       RSTN;
  logic [7:0] DIN;
  logic       DIN_VALID;
  logic       DIN_READY, CFG_SDO, CFG_SEN, CFG_UPD, BUSY, DONE, ERR;

  int total = 0;
  int bad   = 0;

  tfrag_cfg_loader #(.NUM_FRAGS(NF), .HDR(8'hA5)) dut (
    .CLK(CLK), .RSTN(RSTN), .DIN(DIN), .DIN_VALID(DIN_VALID),
    .DIN_READY(DIN_READY), .CFG_SDO(CFG_SDO), .CFG_SEN(CFG_SEN),
    .CFG_UPD(CFG_UPD), .BUSY(BUSY), .DONE(DONE), .ERR(ERR)
  );

  always #5 CLK = ~CLK;

  // Monitor: sampled on the falling edge, away from the active edge.
  int          cyc = 0;
  int          sen_cnt, upd_cnt, xfer_cnt, nready_cnt, sdo_idle_bad, both_bad;
  int          last_xfer_cyc, sen_first_cyc, upd_cyc;
  logic [15:0] sdo_word;

  always @(negedge CLK) begin
    cyc++;
    if (DIN_VALID && DIN_READY) begin
      xfer_cnt++;
      last_xfer_cyc = cyc;
    end
    if (CFG_SEN) begin
      if (sen_cnt == 0) sen_first_cyc = cyc;
      sdo_word = {sdo_word[14:0], CFG_SDO};
      sen_cnt++;
    end
    if (CFG_UPD) begin
      upd_cnt++;
      upd_cyc = cyc;
    end
    if (!CFG_SEN && CFG_SDO) sdo_idle_bad++;
    if (DONE && ERR) both_bad++;
    if (!DIN_READY && RSTN) nready_cnt++;
  end

  task automatic clear_mon();
    sen_cnt = 0; upd_cnt = 0; xfer_cnt = 0; nready_cnt = 0;
    sdo_idle_bad = 0; both_bad = 0; sdo_word = '0;
    last_xfer_cyc = 0; sen_first_cyc = 0; upd_cyc = 0;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // Present one byte and hold it until it has been transferred.
  task automatic send_byte(input logic [7:0] b, input bit gap);
    int n;
    if (gap) begin
      DIN_VALID = 1'b0;
      step();
    end
    DIN = b;
    DIN_VALID = 1'b1;
    n = 0;
    while (!DIN_READY && n < 100) begin
      step();
      n++;
    end
    if (n >= 100) check("ready_timeout", 32'(n), 32'd0);
    step();
  endtask

  typedef struct {
    string       name;
    logic [63:0] bytes;   // byte 0 in bits 7:0
    int          nbytes;
    bit          toggle;
    bit          exp_ok;
    logic [15:0] exp_sdo;
  } vec_t;

  vec_t vecs[6];

  initial begin
    vecs[0] = '{"basic",    64'h0000_0000_6243_21A5, 4, 1'b0, 1'b1, 16'h4321};
    vecs[1] = '{"badsum",   64'h0000_0000_6343_21A5, 4, 1'b0, 1'b0, 16'h0000};
    vecs[2] = '{"junk",     64'h0062_4321_A55A_FF00, 7, 1'b0, 1'b1, 16'h4321};
    vecs[3] = '{"hdr_data", 64'h0000_0000_A500_A5A5, 4, 1'b0, 1'b1, 16'h00A5};
    vecs[4] = '{"toggle",   64'h0000_0000_6243_21A5, 4, 1'b1, 1'b1, 16'h4321};
    vecs[5] = '{"mixed",    64'h0000_0000_FFF0_0FA5, 4, 1'b0, 1'b1, 16'hF00F};

    RSTN = 1'b0;
    DIN = 8'h00;
    DIN_VALID = 1'b0;
    clear_mon();
    #12;
    check("rst_ready", 32'(DIN_READY), 32'd1);
    check("rst_sen",   32'(CFG_SEN),   32'd0);
    check("rst_sdo",   32'(CFG_SDO),   32'd0);
    check("rst_upd",   32'(CFG_UPD),   32'd0);
    check("rst_busy",  32'(BUSY),      32'd0);
    check("rst_done",  32'(DONE),      32'd0);
    check("rst_err",   32'(ERR),       32'd0);
    step();
    RSTN = 1'b1;
    step();

    for (int v = 0; v < 6; v++) begin
      logic [63:0] bb;
      bb = vecs[v].bytes;
      clear_mon();
      for (int i = 0; i < vecs[v].nbytes; i++) begin
        send_byte(bb[8*i +: 8], vecs[v].toggle && i > 0);
        if (i == 0 && vecs[v].nbytes == 4) check({vecs[v].name, "_busy_mid"}, 32'(BUSY), 32'd1);
      end
      DIN_VALID = 1'b0;
      for (int c = 0; c < 22; c++) step();
      check({vecs[v].name, "_xfers"},  32'(xfer_cnt), 32'(vecs[v].nbytes));
      check({vecs[v].name, "_sen"},    32'(sen_cnt),  vecs[v].exp_ok ? 32'd16 : 32'd0);
      check({vecs[v].name, "_upd"},    32'(upd_cnt),  vecs[v].exp_ok ? 32'd1 : 32'd0);
      check({vecs[v].name, "_nready"}, 32'(nready_cnt), vecs[v].exp_ok ? 32'd17 : 32'd0);
      check({vecs[v].name, "_done"},   32'(DONE), vecs[v].exp_ok ? 32'd1 : 32'd0);
      check({vecs[v].name, "_err"},    32'(ERR),  vecs[v].exp_ok ? 32'd0 : 32'd1);
      check({vecs[v].name, "_busy"},   32'(BUSY), 32'd0);
      check({vecs[v].name, "_ready"},  32'(DIN_READY), 32'd1);
      check({vecs[v].name, "_sdo_idle"}, 32'(sdo_idle_bad), 32'd0);
      check({vecs[v].name, "_both"},   32'(both_bad), 32'd0);
      if (vecs[v].exp_ok) begin
        check({vecs[v].name, "_sdo"},     32'(sdo_word), 32'(vecs[v].exp_sdo));
        check({vecs[v].name, "_lat_sen"}, 32'(sen_first_cyc - last_xfer_cyc), 32'd1);
        check({vecs[v].name, "_lat_upd"}, 32'(upd_cyc - last_xfer_cyc), 32'd17);
      end
    end

    // Reset in the middle of the shift: no update strobe, then a clean reload.
    clear_mon();
    send_byte(8'hA5, 1'b0);
    send_byte(8'h21, 1'b0);
    send_byte(8'h43, 1'b0);
    send_byte(8'h62, 1'b0);
    DIN_VALID = 1'b0;
    begin
      int n;
      n = 0;
      while (sen_cnt < 7 && n < 50) begin
        step();
        n++;
      end
      check("mid_rst_reach", 32'(sen_cnt), 32'd7);
    end
    RSTN = 1'b0;
    #1;
    check("mid_rst_sen",   32'(CFG_SEN),   32'd0);
    check("mid_rst_sdo",   32'(CFG_SDO),   32'd0);
    check("mid_rst_upd",   32'(CFG_UPD),   32'd0);
    check("mid_rst_busy",  32'(BUSY),      32'd0);
    check("mid_rst_done",  32'(DONE),      32'd0);
    check("mid_rst_ready", 32'(DIN_READY), 32'd1);
    step();
    step();
    RSTN = 1'b1;
    step();
    check("mid_rst_no_upd", 32'(upd_cnt), 32'd0);
    clear_mon();
    send_byte(8'hA5, 1'b0);
    send_byte(8'hFF, 1'b0);
    send_byte(8'hFF, 1'b0);
    send_byte(8'h00, 1'b0);
    DIN_VALID = 1'b0;
    for (int c = 0; c < 22; c++) step();
    check("reload_sen",  32'(sen_cnt),  32'd16);
    check("reload_sdo",  32'(sdo_word), 32'h0000_FFFF);
    check("reload_upd",  32'(upd_cnt),  32'd1);
    check("reload_done", 32'(DONE),     32'd1);
    check("reload_err",  32'(ERR),      32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
